// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - instruction RAM owner: byte-stream loader, core reset/clock gating, zero-latency fetch
//
// Fills an internal instruction RAM from a valid/ready byte stream (16-bit
// little-endian word count, then little-endian 32-bit words), holds the core
// in reset with its clock disabled until the load completes, then serves
// combinational fetches for the core's pc.
//
// Ports:
//   clk, rst            clock (rising edge) and synchronous active-high reset
//   rx_data/rx_valid    incoming byte stream
//   rx_ready            loader accepts a byte this cycle
//   reload              pulse in RUN: return to header parsing
//   pc                  core byte fetch address
//   inst_out            instruction for pc (NOP_WORD when not loaded/misaligned)
//   core_rstB           registered active-low reset to the core
//   core_clkEn          clock enable to the core
//   busy                parsing header or loading words
//   err_overflow        sticky: header count exceeded DEPTH
//   fault_misaligned    sticky: misaligned fetch while the core runs
//   words_loaded        number of valid words in the RAM
module imem_loader #(
  parameter int          DEPTH    = 1024,
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  input  logic [31:0]       pc,
  output logic [31:0]       inst_out,
  output logic              core_rstB,
  output logic              core_clkEn,
  output logic              busy,
  output logic              err_overflow,
  output logic              fault_misaligned,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_LOAD,
    S_RUN,
    S_ERR
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0]     mem [DEPTH];
  logic [7:0]      cnt_lo;
  logic [15:0]     count;
  logic [1:0]      lane;
  logic [ADDR_W:0] idx;
  logic [ADDR_W:0] idx_inc;
  logic [23:0]     bytes_lo;

  logic        xfer;
  logic [15:0] hdr_count;
  logic        hdr_over;
  logic        hdr_zero;
  logic        word_done;
  logic        last_word;

  logic [ADDR_W-1:0] fetch_idx;
  logic              fetch_bad;

  assign busy       = (state == S_HDR0) || (state == S_HDR1) || (state == S_LOAD);
  // Gated by rst so no byte can slip in on a reset edge.
  assign rx_ready   = busy && !rst;
  assign core_clkEn = (state == S_RUN);
  assign xfer       = rx_valid && rx_ready;

  // Header is evaluated using the byte arriving now as the high half.
  assign hdr_count = {rx_data, cnt_lo};
  assign hdr_over  = 32'(hdr_count) > DEPTH;
  assign hdr_zero  = (hdr_count == 16'd0);

  assign idx_inc   = idx + 1'b1;
  assign word_done = xfer && (state == S_LOAD) && (lane == 2'd3);
  assign last_word = word_done && (16'(idx_inc) == count);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_HDR0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HDR0: if (xfer) state_nxt = S_HDR1;
      S_HDR1: begin
        if (xfer) begin
          if (hdr_over)      state_nxt = S_ERR;
          else if (hdr_zero) state_nxt = S_RUN;
          else               state_nxt = S_LOAD;
        end
      end
      S_LOAD: if (last_word) state_nxt = S_RUN;
      S_RUN:  if (reload) state_nxt = S_HDR0;
      S_ERR:  state_nxt = S_ERR;
      default: state_nxt = S_HDR0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_lo           <= '0;
      count            <= '0;
      lane             <= '0;
      idx              <= '0;
      bytes_lo         <= '0;
      words_loaded     <= '0;
      err_overflow     <= 1'b0;
      fault_misaligned <= 1'b0;
      core_rstB        <= 1'b0;
    end else begin
      // Dropping on the reload edge itself keeps the core from fetching
      // while the RAM is being rewritten.
      core_rstB <= (state == S_RUN) && !reload;
      case (state)
        S_HDR0: begin
          if (xfer) cnt_lo <= rx_data;
        end
        S_HDR1: begin
          if (xfer) begin
            count        <= hdr_count;
            words_loaded <= '0;
            idx          <= '0;
            lane         <= '0;
            if (hdr_over) err_overflow <= 1'b1;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            lane <= lane + 2'd1;
            case (lane)
              2'd0: bytes_lo[7:0]   <= rx_data;
              2'd1: bytes_lo[15:8]  <= rx_data;
              2'd2: bytes_lo[23:16] <= rx_data;
              default: begin
                idx          <= idx_inc;
                words_loaded <= idx_inc;
              end
            endcase
          end
        end
        S_RUN: begin
          if (reload) begin
            lane             <= '0;
            idx              <= '0;
            words_loaded     <= '0;
            fault_misaligned <= 1'b0;
          end else if (core_rstB && (pc[1:0] != 2'b00)) begin
            fault_misaligned <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM is deliberately not reset; words_loaded alone decides validity.
  always_ff @(posedge clk) begin
    if (word_done) begin
      mem[idx[ADDR_W-1:0]] <= {rx_data, bytes_lo};
    end
  end

  assign fetch_idx = pc[ADDR_W+1:2];
  assign fetch_bad = (pc[1:0] != 2'b00)
                  || ({1'b0, fetch_idx} >= words_loaded)
                  || (pc[31:ADDR_W+2] != '0);

  always_comb begin
    inst_out = NOP_WORD;
    if (!fetch_bad) inst_out = mem[fetch_idx];
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

  localparam int DEPTH = 1024;
  localparam int ADDR_W = 10;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              reload = 1'b0;
  logic [31:0]       pc = 32'h0;
  logic [31:0]       inst_out;
  logic              core_rstB;
  logic              core_clkEn;
  logic              busy;
  logic              err_overflow;
  logic              fault_misaligned;
  logic [ADDR_W:0]   words_loaded;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] sb_pc;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .reload(reload), .pc(pc), .inst_out(inst_out),
    .core_rstB(core_rstB), .core_clkEn(core_clkEn), .busy(busy),
    .err_overflow(err_overflow), .fault_misaligned(fault_misaligned),
    .words_loaded(words_loaded)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offers one byte; with throttle, rx_valid is idle on 2 of 3 cycles.
  task automatic send_byte(input logic [7:0] b, input bit throttle);
    int waited = 0;
    forever begin
      @(negedge clk);
      if (throttle && ($urandom_range(0, 2) != 0)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end else begin
        rx_valid = 1'b1;
        rx_data  = b;
        if (rx_ready) begin
          @(posedge clk);
          #1;
          rx_valid = 1'b0;
          return;
        end
      end
      waited++;
      if (waited > 60) begin
        check("byte_accept_timeout", 32'(rx_ready), 32'd1);
        rx_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit throttle);
    sb_q.push_back('{addr: sb_pc, data: w});
    sb_pc += 4;
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], throttle);
  endtask

  task automatic send_header(input logic [15:0] n, input bit throttle);
    sb_pc = 0;
    send_byte(n[7:0], throttle);
    send_byte(n[15:8], throttle);
  endtask

  task automatic drain_sb(input string tag);
    sb_t e;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      @(negedge clk);
      pc = e.addr;
      #1;
      check(tag, inst_out, e.data);
    end
    pc = 0;
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    check("reload_rstB_low", 32'(core_rstB), 32'd0);
    check("reload_busy", 32'(busy), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] prog[3] = '{32'h0050_0093, 32'h0010_0113, 32'h0020_81B3};

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_core_rstB", 32'(core_rstB), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_err", 32'(err_overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(rx_ready), 32'd1);

    // Three-word program, unthrottled
    send_header(16'd3, 1'b0);
    for (int i = 0; i < 3; i++) send_word(prog[i], 1'b0);
    check("run_clken", 32'(core_clkEn), 32'd1);
    check("run_rstB_still_low", 32'(core_rstB), 32'd0);
    check("run_words", 32'(words_loaded), 32'd3);
    check("run_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("run_rstB_high", 32'(core_rstB), 32'd1);
    drain_sb("prog3_fetch");
    @(negedge clk);
    pc = 12;
    rx_valid = 1'b1;
    #1;
    check("prog3_beyond", inst_out, NOP);
    check("run_no_ready", 32'(rx_ready), 32'd0);
    @(negedge clk);
    rx_valid = 1'b0;
    pc = 0;

    // Same program throttled after a reload
    pulse_reload();
    send_header(16'd3, 1'b1);
    for (int i = 0; i < 3; i++) send_word(prog[i], 1'b1);
    check("thr_words", 32'(words_loaded), 32'd3);
    drain_sb("thr_fetch");

    // Misaligned fetch in RUN
    @(negedge clk);
    pc = 2;
    #1;
    check("misal_nop", inst_out, NOP);
    @(posedge clk);
    #1;
    check("misal_fault", 32'(fault_misaligned), 32'd1);
    pc = 0;
    repeat (3) @(negedge clk);
    check("misal_sticky", 32'(fault_misaligned), 32'd1);

    // Reload with one word
    pulse_reload();
    check("reload_clears_fault", 32'(fault_misaligned), 32'd0);
    send_header(16'd1, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
    check("one_words", 32'(words_loaded), 32'd1);
    drain_sb("one_fetch");
    @(negedge clk);
    pc = 4;
    #1;
    check("one_beyond", inst_out, NOP);
    pc = 32'h1000_0000;
    #1;
    check("high_pc_nop", inst_out, NOP);
    pc = 0;

    // Zero-length program
    pulse_reload();
    send_header(16'd0, 1'b0);
    check("zero_run", 32'(core_clkEn), 32'd1);
    check("zero_words", 32'(words_loaded), 32'd0);
    for (int a = 0; a < 16; a += 4) begin
      @(negedge clk);
      pc = a;
      #1;
      check("zero_fetch", inst_out, NOP);
    end
    pc = 0;

    // Reset after 6 of 8 data bytes
    pulse_reload();
    send_header(16'd2, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h40 + i), 1'b0);
    check("part_words", 32'(words_loaded), 32'd1);
    do_reset();
    @(negedge clk);
    check("part_rst_words", 32'(words_loaded), 32'd0);
    check("part_rst_ready", 32'(rx_ready), 32'd1);
    check("part_rst_busy", 32'(busy), 32'd1);
    check("part_rst_rstB", 32'(core_rstB), 32'd0);
    check("part_rst_fetch", inst_out, NOP);
    sb_q.delete();

    // Overflow header 1025 with rx_valid held high afterwards
    send_header(16'h0401, 1'b0);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    check("ovf_err", 32'(err_overflow), 32'd1);
    check("ovf_ready", 32'(rx_ready), 32'd0);
    check("ovf_busy", 32'(busy), 32'd0);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      check("ovf_hold_rstB", 32'(core_rstB), 32'd0);
    end
    check("ovf_sticky", 32'(err_overflow), 32'd1);
    check("ovf_words", 32'(words_loaded), 32'd0);
    rx_valid = 1'b0;
    do_reset();
    @(negedge clk);
    check("ovf_rst_clear", 32'(err_overflow), 32'd0);

    // Full-depth load
    send_header(16'(DEPTH), 1'b0);
    for (int i = 0; i < DEPTH; i++) send_word({16'(i) ^ 16'hA5C3, 16'(i)}, 1'b0);
    check("full_words", 32'(words_loaded), 32'(DEPTH));
    check("full_run", 32'(core_clkEn), 32'd1);
    drain_sb("full_fetch");
    @(negedge clk);
    pc = 32'(DEPTH * 4);
    #1;
    check("full_wrap_nop", inst_out, NOP);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction-side responder for the RV32I core: owns the instruction RAM and returns the instruction word for the core's `pc` on the same cycle.
- Before execution, fills the RAM from a byte stream (valid/ready) sent by the host link. The stream is a 16-bit word count followed by little-endian instruction words.
- Holds the core in reset and clock-disabled until the load completes. On `reload`, returns to loading.

Parameters:
- DEPTH, 1024, instruction RAM size in 32-bit words; power of two.
- ADDR_W, 10, log2(DEPTH).
- NOP_WORD, 32'h00000013, word returned for unloaded or misaligned fetches (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- reload  in  1  single-cycle pulse; restart loading (honoured in RUN only).
- pc  in  32  core fetch address (byte address).
- inst_out  out  32  instruction for pc; drives core inst_in.
- core_rstB  out  1  active-low reset to core, registered.
- core_clkEn  out  1  clock enable to core.
- busy  out  1  state is HDR0, HDR1 or LOAD.
- err_overflow  out  1  sticky; header count exceeded DEPTH.
- fault_misaligned  out  1  sticky; RUN fetch with pc[1:0] != 0.
- words_loaded  out  ADDR_W+1  number of valid words in RAM.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=HDR0, core_rstB=0, err_overflow=0, fault_misaligned=0, words_loaded=0.
  - Byte lane=0 and write index=0.
  - RAM contents are not cleared.
  - rx_ready is forced 0 while rst=1.
- Handshake:
  - A byte transfers on any edge with rx_valid & rx_ready.
  - rx_ready = 1 in HDR0, HDR1 and LOAD; 0 in RUN and ERR. It is combinational from state.
  - rx_data is ignored when no transfer occurs.
- States:
  - HDR0: transfer latches count[7:0] and moves to HDR1.
  - HDR1: transfer latches count[15:8], then evaluates the full count:
    - count > DEPTH: go to ERR.
    - count == 0: go to RUN.
    - otherwise: go to LOAD with write index=0 and lane=0.
    - words_loaded is cleared to 0 on entry to HDR1's evaluation.
  - LOAD: each transfer stores the byte in lane 0..3 (lane 0 = bits 7:0). On the lane-3 transfer:
    - write mem[idx] = {b3,b2,b1,b0} on that edge;
    - words_loaded = idx+1, idx increments, lane wraps to 0;
    - if idx+1 == count, go to RUN.
  - RUN: rx_ready=0 and core_clkEn=1. reload=1 moves to HDR0 next edge; lane, idx, words_loaded and fault_misaligned are cleared.
  - ERR: err_overflow=1, core held in reset. Only rst exits.
- Core control:
  - core_rstB <= (state==RUN && !reload), registered. The core therefore leaves reset one cycle after RUN is entered.
  - On a reload edge, core_rstB drops on that same edge.
  - core_clkEn = (state==RUN), combinational.
- Fetch (RUN or not):
  - inst_out is combinational with zero latency.
  - If pc[1:0] != 0 or pc[ADDR_W+1:2] >= words_loaded, or pc[31:ADDR_W+2] != 0, inst_out = NOP_WORD.
  - Otherwise inst_out = mem[pc[ADDR_W+1:2]].
  - fault_misaligned sets on a clk edge when state==RUN, core_rstB=1 and pc[1:0] != 0.
- Boundaries:
  - Write-before-read on the same word in the same cycle returns the old data. This case cannot occur outside LOAD, when the core is held.
  - count == DEPTH fills every location; count == DEPTH+1 goes to ERR.
  - rst during LOAD abandons the partial word; already-written words remain but words_loaded=0, so all fetches return NOP_WORD.
  - rx_valid held high across the HDR1 to ERR or RUN transition: no further bytes are taken.

Test Plan:
- Load count=3 (bytes 03 00), then words 0x00500093, 0x00100113, 0x002081B3 as little-endian bytes.
  - words_loaded=3, state RUN.
  - core_rstB rises exactly one cycle after the last byte's edge +1.
  - pc=0/4/8 returns the three words; pc=12 returns 0x00000013.
- Throttle rx_valid randomly (1 of 3 cycles) on the same stream → identical RAM contents; no byte dropped or duplicated. rx_ready=0 in RUN despite rx_valid=1.
- Header 0x0401 (1025, DEPTH=1024) → err_overflow=1, rx_ready=0, core_rstB stays 0 for 100 cycles.
- Header 0 → RUN immediately after the second header byte; every pc returns NOP_WORD.
- In RUN, pulse reload and send count=1, word 0xDEADBEEF:
  - core_rstB=0 on the reload edge, busy=1 during reload;
  - afterwards pc=0 returns 0xDEADBEEF and pc=4 returns NOP_WORD.
  - Separately, drive pc=2 in RUN → inst_out=0x00000013 and fault_misaligned=1, sticky until reload or rst.
- Assert rst after 6 of 8 data bytes → words_loaded=0, state HDR0, rx_ready=1 the cycle after rst deasserts, core_rstB=0.
